// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo.
// The master side (the producer) drives the baud divisor, the enable, the write
// handshake and the overrun clear. The slave side (the transmitter) returns ready,
// the serial line, busy, the FIFO fill level and the sticky overrun flag.
//   baud_div     : clocks per bit minus 1
//   tx_enable    : permits new frames to start
//   tx_valid     : write request
//   tx_data      : write byte
//   clr_over_run : clears tx_over_run
//   tx_ready     : FIFO can accept a byte
//   tx_out       : serial line, idle high
//   tx_busy      : frame in progress
//   fifo_count   : bytes held
//   tx_over_run  : sticky write-while-full flag
interface uart_tx_fifo_if;
  logic [15:0] baud_div;
  logic        tx_enable;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        clr_over_run;
  logic        tx_ready;
  logic        tx_out;
  logic        tx_busy;
  logic [4:0]  fifo_count;
  logic        tx_over_run;

  modport master (
    output baud_div, tx_enable, tx_valid, tx_data, clr_over_run,
    input  tx_ready, tx_out, tx_busy, fifo_count, tx_over_run
  );

  modport slave (
    input  baud_div, tx_enable, tx_valid, tx_data, clr_over_run,
    output tx_ready, tx_out, tx_busy, fifo_count, tx_over_run
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Bytes written through the bus are buffered, then sent as 8N1 frames (optionally
// with a parity bit) at baud_div+1 clocks per bit, LSB first.
// Ports:
//   txclk   : sole clock, rising edge
//   reset_n : asynchronous active-low reset; aborts any frame and empties the FIFO
//   bus     : uart_tx_fifo_if slave modport (see the interface for signal roles)
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,  // power of two, 2..16
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic           txclk,
  input logic           reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          over_run_q, over_run_d;
  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;

  logic push, pop, can_start, bit_done, start_frame;

  // Ready comes from the registered count only, so it never depends on this cycle's pop.
  assign bus.tx_ready    = (count_q != DepthCnt);
  assign bus.tx_out      = tx_q;
  assign bus.tx_busy     = (state_q != StIdle);
  assign bus.fifo_count  = count_q;
  assign bus.tx_over_run = over_run_q;

  assign push      = bus.tx_valid && bus.tx_ready;
  assign can_start = bus.tx_enable && (count_q != 5'd0);
  assign bit_done  = (cnt_q == 16'd0);

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    over_run_d = over_run_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    if (bus.tx_valid && !bus.tx_ready) over_run_d = 1'b1;
    else if (bus.clr_over_run)         over_run_d = 1'b0;
  end

  // Transmit FSM
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (can_start) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          cnt_d     = baud_q;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = baud_q;
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StParity: begin
        if (bit_done) begin
          cnt_d   = baud_q;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (can_start) begin
            start_frame = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = mem_q[rd_ptr_q];
      parity_d  = (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
      baud_d    = bus.baud_div;
      cnt_d     = bus.baud_div;
      bit_idx_d = 3'd0;
      tx_d      = 1'b0;
      state_d   = StStart;
    end
  end

  // Storage array needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge txclk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      over_run_q <= 1'b0;
      state_q    <= StIdle;
      baud_q     <= 16'd0;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      over_run_q <= over_run_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a default instance checked by a frame
// monitor against a queue of expected bytes, and a parity instance (odd parity)
// checked directly against a locally built bit pattern.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if tx_if ();
  uart_tx_fifo_if txp_if ();

  uart_tx_fifo #(.FIFO_DEPTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .txclk  (clk),
    .reset_n(rst_n),
    .bus    (tx_if)
  );

  uart_tx_fifo #(.FIFO_DEPTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_p (
    .txclk  (clk),
    .reset_n(rst_n),
    .bus    (txp_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];      // bytes expected on tx_out, in order
  int         starts[$];  // cycle stamps of observed start bits
  int         exp_div = 3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept, output int acc_cyc);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    check_eq("wr_ready", tx_if.tx_ready, accept);
    if (accept) sb.push_back(b);
    @(posedge clk);
    #1;
    acc_cyc        = cyc;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit need_empty, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!tx_if.tx_busy && (!need_empty || tx_if.fifo_count == 5'd0)) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1'b1);
  endtask

  // Frame monitor for the default instance.
  initial begin
    logic [9:0] bits;
    logic [7:0] b;
    int         div;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx_if.tx_out === 1'b0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_frame", 1'b1, 1'b0);
        end else begin
          b = sb.pop_front();
          div = exp_div;
          starts.push_back(cyc);
          bits = {1'b1, b, 1'b0};
          aborted = 1'b0;
          for (int i = 0; i < 10 && !aborted; i++) begin
            for (int c = 0; c <= div && !aborted; c++) begin
              if (!(i == 0 && c == 0)) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
              end else begin
                check_eq("tx_bit", tx_if.tx_out, bits[i]);
                check_eq("tx_busy", tx_if.tx_busy, 1'b1);
              end
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int n;
    logic [10:0] pbits;
    logic [7:0]  pb;

    tx_if.baud_div      = 16'd3;
    tx_if.tx_enable     = 1'b1;
    tx_if.tx_valid      = 1'b0;
    tx_if.tx_data       = 8'h00;
    tx_if.clr_over_run  = 1'b0;
    txp_if.baud_div     = 16'd1;
    txp_if.tx_enable    = 1'b1;
    txp_if.tx_valid     = 1'b0;
    txp_if.tx_data      = 8'h00;
    txp_if.clr_over_run = 1'b0;

    // Reset state
    #12;
    check_eq("rst_tx_out", tx_if.tx_out, 1'b1);
    check_eq("rst_busy", tx_if.tx_busy, 1'b0);
    check_eq("rst_ready", tx_if.tx_ready, 1'b1);
    check_eq("rst_count", tx_if.fifo_count, 5'd0);
    check_eq("rst_over_run", tx_if.tx_over_run, 1'b0);
    check_eq("rst_p_tx_out", txp_if.tx_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte, 4 clocks per bit
    exp_div = 3;
    tx_if.baud_div = 16'd3;
    starts.delete();
    write_byte(8'hA5, 1'b1, acc);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_if.tx_busy) n++;
      else if (n > 0) break;
    end
    check_eq("single_busy_len", n, 40);
    check_eq("single_latency", (starts.size() > 0) ? starts[0] - acc : -1, 1);
    wait_idle(50, 1'b1, "single_idle");

    // Back-to-back at 1 clock per bit
    @(posedge clk);
    #1;
    exp_div = 0;
    tx_if.baud_div = 16'd0;
    starts.delete();
    write_byte(8'h00, 1'b1, acc);
    write_byte(8'hFF, 1'b1, acc);
    wait_idle(100, 1'b1, "b2b_idle");
    check_eq("b2b_frames", starts.size(), 2);
    check_eq("b2b_gap", (starts.size() == 2) ? starts[1] - starts[0] : -1, 10);

    // Overflow with transmission disabled
    @(posedge clk);
    #1;
    tx_if.tx_enable = 1'b0;
    exp_div = 1;
    tx_if.baud_div = 16'd1;
    for (int i = 0; i < 8; i++) write_byte(8'(i * 37 + 5), 1'b1, acc);
    check_eq("ovf_over_run_pre", tx_if.tx_over_run, 1'b0);
    write_byte(8'hEE, 1'b0, acc);
    check_eq("ovf_count", tx_if.fifo_count, 5'd8);
    check_eq("ovf_ready", tx_if.tx_ready, 1'b0);
    check_eq("ovf_over_run", tx_if.tx_over_run, 1'b1);
    tx_if.clr_over_run = 1'b1;
    @(posedge clk);
    #1;
    tx_if.clr_over_run = 1'b0;
    check_eq("ovf_cleared", tx_if.tx_over_run, 1'b0);
    check_eq("ovf_count_kept", tx_if.fifo_count, 5'd8);
    tx_if.clr_over_run = 1'b1;
    write_byte(8'hDD, 1'b0, acc);
    tx_if.clr_over_run = 1'b0;
    check_eq("ovf_set_wins", tx_if.tx_over_run, 1'b1);
    tx_if.clr_over_run = 1'b1;
    @(posedge clk);
    #1;
    tx_if.clr_over_run = 1'b0;
    tx_if.tx_enable = 1'b1;
    wait_idle(300, 1'b1, "ovf_drain_idle");
    check_eq("ovf_sb_empty", sb.size(), 0);

    // Mid-frame baud change and enable drop
    @(posedge clk);
    #1;
    exp_div = 3;
    tx_if.baud_div = 16'd3;
    write_byte(8'h3C, 1'b1, acc);
    write_byte(8'hC3, 1'b1, acc);
    repeat (8) @(posedge clk);
    #1;
    tx_if.baud_div  = 16'd7;
    tx_if.tx_enable = 1'b0;
    wait_idle(100, 1'b0, "mid_first_done");
    repeat (20) @(negedge clk);
    check_eq("mid_stays_idle", tx_if.tx_busy, 1'b0);
    check_eq("mid_queued", tx_if.fifo_count, 5'd1);
    check_eq("mid_line_high", tx_if.tx_out, 1'b1);

    // Reset in the middle of a frame
    exp_div = 7;
    tx_if.tx_enable = 1'b1;
    @(posedge clk);
    #1;
    write_byte(8'h55, 1'b1, acc);
    repeat (20) @(posedge clk);
    #2;
    check_eq("rst_mid_busy_pre", tx_if.tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx_out", tx_if.tx_out, 1'b1);
    check_eq("rst_mid_count", tx_if.fifo_count, 5'd0);
    check_eq("rst_mid_busy", tx_if.tx_busy, 1'b0);
    check_eq("rst_mid_ready", tx_if.tx_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_idle", tx_if.tx_busy, 1'b0);

    // Normal operation after reset
    @(posedge clk);
    #1;
    exp_div = 0;
    tx_if.baud_div = 16'd0;
    write_byte(8'h96, 1'b1, acc);
    wait_idle(50, 1'b1, "post_rst_frame");
    check_eq("post_rst_sb_empty", sb.size(), 0);

    // Odd parity instance: 0x03, 2 clocks per bit
    @(posedge clk);
    #1;
    pb = 8'h03;
    pbits = {1'b1, ~(^pb), pb, 1'b0};
    txp_if.tx_valid = 1'b1;
    txp_if.tx_data  = pb;
    @(posedge clk);
    #1;
    txp_if.tx_valid = 1'b0;
    @(negedge clk);
    check_eq("par_pre_idle", txp_if.tx_out, 1'b1);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      check_eq("par_bit", txp_if.tx_out, pbits[i / 2]);
      check_eq("par_busy", txp_if.tx_busy, 1'b1);
    end
    @(negedge clk);
    check_eq("par_len_end", txp_if.tx_busy, 1'b0);
    check_eq("par_line_idle", txp_if.tx_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, giving the number of buffered bytes; it SHALL be a power of two, 2..16.
REQ-002 SHALL provide parameter PARITY_EN, default 0; when 1, a parity bit is inserted between the data bits and the stop bit.
REQ-003 SHALL provide parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: txclk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL provide these remaining ports:
- baud_div  in  16  clocks per bit minus 1.
- tx_enable  in  1  permits starting new frames.
- tx_valid  in  1  write request.
- tx_data  in  8  write byte.
- tx_ready  out  1  FIFO can accept a byte.
- tx_out  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress.
- fifo_count  out  5  bytes held.
- tx_over_run  out  1  sticky write-while-full flag.
- clr_over_run  in  1  clears tx_over_run.

Function
REQ-006 SHALL accept a byte into the FIFO on a rising edge where tx_valid=1 and tx_ready=1.
REQ-007 SHALL drive tx_ready = (fifo_count != FIFO_DEPTH), derived from the registered count only.
REQ-008 SHALL, for tx_valid=1 while full, drop the byte and set tx_over_run=1 on that edge.
REQ-009 SHALL hold tx_over_run until an edge with clr_over_run=1; if set and clear coincide, set wins.
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tx_busy=1 in every state except IDLE.
REQ-011 SHALL, in IDLE with tx_enable=1 and fifo_count>0, on the next edge:
- pop the head byte into the shift register;
- latch baud_div;
- drive tx_out=0;
- enter START.
REQ-012 SHALL hold each bit for exactly latched baud_div+1 clocks, timed by a down-counter reloaded from the latched value at each bit boundary.
- baud_div=0 yields 1 clock per bit.
- Changes to baud_div mid-frame SHALL have no effect until the next frame start.
REQ-013 SHALL send 8 data bits LSB first in DATA, then the PARITY state only if PARITY_EN=1, then STOP.
- Parity bit = XOR of the data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-014 SHALL drive tx_out=1 for one full bit time in STOP. At the end of STOP:
- if tx_enable=1 and fifo_count>0, go directly to START (same actions as REQ-011), with no idle gap;
- otherwise go to IDLE with tx_out=1.
REQ-015 SHALL finish an in-progress frame unchanged when tx_enable deasserts mid-frame, and SHALL then start no new frame.
REQ-016 SHALL, on an edge with simultaneous accepted write and pop, leave fifo_count unchanged, and wrap both pointers modulo FIFO_DEPTH.
REQ-017 SHALL make tx_out glitch-free by driving it directly from a register.
REQ-018 SHALL give single-byte latency as follows: for a byte accepted at edge k into an empty FIFO while IDLE and enabled, tx_out falls at edge k+1. Total frame length SHALL be (10+PARITY_EN)*(baud_div+1) clocks.

Reset
REQ-019 SHALL, while reset_n=0, asynchronously force the following and return to IDLE:
- tx_out=1, tx_busy=0, tx_ready=1, fifo_count=0, tx_over_run=0;
- FIFO pointers, baud counter, bit index and shift register to 0.
REQ-020 SHALL abort any in-progress frame on reset assertion; tx_out goes high immediately and buffered bytes are discarded.
REQ-021 SHALL begin operating normally on the first rising edge after reset_n deasserts.

Verification
REQ-022 Single byte: baud_div=3, PARITY_EN=0, write 0xA5 into an idle FIFO -> tx_out pattern 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; tx_busy high for 40 clocks.
REQ-023 Back-to-back: write 0x00 then 0xFF with baud_div=0 -> 20 contiguous bit times, no idle gap between stop bit and second start bit.
REQ-024 Overflow: FIFO_DEPTH=8, tx_enable=0, write 9 bytes -> fifo_count=8, tx_ready=0, tx_over_run=1; pulse clr_over_run -> tx_over_run=0.
REQ-025 Parity: PARITY_EN=1, PARITY_ODD=1, byte 0x03, baud_div=1 -> parity bit=1, frame length 22 clocks.
REQ-026 Mid-frame events: change baud_div 3->7 and drop tx_enable during DATA -> current frame completes at 4 clocks/bit, the next byte stays queued. Then assert reset_n=0 mid-frame -> tx_out=1 and fifo_count=0 immediately.
